// File: rtl/risc_pkg.sv
// -----------------------------------------------------------------------------
// risc_pkg
// Definitions shared by the 8-bit RISC CPU control path and the ALU:
//   - opcode encodings taken from IR[7:5]
//   - sequencer state encodings (these values appear on the STATE debug port)
//   - bit positions inside the sequencer's internal control word
//   - small helpers that classify states and opcodes
// -----------------------------------------------------------------------------
package risc_pkg;

    // Opcodes, IR[7:5]. The ALU decodes the same values.
    localparam logic [2:0] OP_HALT  = 3'b000;
    localparam logic [2:0] OP_JRZ   = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_AND   = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_LOAD  = 3'b101;
    localparam logic [2:0] OP_STORE = 3'b110;
    localparam logic [2:0] OP_JUMP  = 3'b111;

    // Sequencer states. The encodings are visible on STATE, so they are fixed.
    typedef enum logic [2:0] {
        FETCH_ADDR = 3'd0,
        FETCH_WAIT = 3'd1,
        DECODE     = 3'd2,
        OP_ADDR    = 3'd3,
        OP_WAIT    = 3'd4,
        EXECUTE    = 3'd5,
        WRITEBACK  = 3'd6,
        HALTED     = 3'd7
    } state_t;

    // Bit positions in the internal control word, one bit per strobe.
    localparam int CW_SEL    = 0;
    localparam int CW_RD     = 1;
    localparam int CW_WR     = 2;
    localparam int CW_LD_IR  = 3;
    localparam int CW_INC_PC = 4;
    localparam int CW_LD_PC  = 5;
    localparam int CW_LD_AC  = 6;
    localparam int CW_DATA_E = 7;
    localparam int CW_ALU_EN = 8;
    localparam int CW_HALT   = 9;
    localparam int CW_W      = 10;

    // States in which the sequencer is waiting for MEM_READY.
    function automatic logic is_wait_state(input state_t s);
        return (s == FETCH_WAIT) || (s == OP_WAIT) || (s == WRITEBACK);
    endfunction

    // Opcodes that read an operand from memory before executing.
    function automatic logic is_read_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LOAD);
    endfunction

endpackage : risc_pkg

// File: rtl/risc_wait_timer.sv
// -----------------------------------------------------------------------------
// risc_wait_timer
// Counts how many cycles the sequencer has been waiting for memory. It flags
// expiry when the count has reached WAIT_MAX and memory is still not ready.
//
// Ports:
//   CLK        in   system clock, rising edge
//   RST_N      in   asynchronous active-low reset
//   i_count    in   sequencer is in a memory wait state
//   i_clear    in   sequencer changes state at the next edge
//   i_ready    in   MEM_READY
//   o_expired  out  wait budget exhausted this cycle (combinational)
// -----------------------------------------------------------------------------
module risc_wait_timer #(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned TO_W     = 4
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic i_count,
    input  logic i_clear,
    input  logic i_ready,
    output logic o_expired
);

    localparam logic [TO_W-1:0] LP_MAX = TO_W'(WAIT_MAX);

    logic [TO_W-1:0] r_cnt;

    // The counter never wraps. Once it reaches LP_MAX with memory still not
    // ready, the sequencer leaves the wait state, and that state change clears
    // the counter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_count && !i_ready) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // If MEM_READY arrives in the same cycle as expiry, the access completes
    // normally and no error is raised.
    assign o_expired = i_count && !i_ready && (r_cnt == LP_MAX);

endmodule : risc_wait_timer

// File: rtl/risc_ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// risc_ctrl_sequencer
// Instruction sequencer for the 8-bit RISC CPU. Each instruction passes
// through fetch, decode, operand access, execute and writeback. The block
// drives the memory handshake and the datapath load strobes. It does not
// contain the datapath itself.
//
// Ports:
//   CLK, RST_N     clock (rising edge) and asynchronous active-low reset
//   OPCODE[2:0]    IR[7:5]
//   ALU_ZERO_FLAG  ACC == 0
//   MEM_READY      memory completes the current access this cycle
//   RUN            restart pulse, honoured only in HALTED
//   SEL            address mux: 1 = PC, 0 = IR operand field
//   RD / WR        memory read / write request
//   LD_IR, INC_PC, LD_PC, LD_AC   datapath load strobes for the next edge
//   DATA_E         ALU_OUT drives DATA_BUS
//   ALU_EN         ALU clock enable
//   HALT           CPU halted
//   BUS_ERR        sticky memory-timeout flag, cleared by RUN
//   STATE[2:0]     current state encoding (debug)
// -----------------------------------------------------------------------------
module risc_ctrl_sequencer
    import risc_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned TO_W     = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [2:0] OPCODE,
    input  logic       ALU_ZERO_FLAG,
    input  logic       MEM_READY,
    input  logic       RUN,
    output logic       SEL,
    output logic       RD,
    output logic       WR,
    output logic       LD_IR,
    output logic       INC_PC,
    output logic       LD_PC,
    output logic       LD_AC,
    output logic       DATA_E,
    output logic       ALU_EN,
    output logic       HALT,
    output logic       BUS_ERR,
    output logic [2:0] STATE
);

    state_t          r_state;
    state_t          w_state_next;
    logic [2:0]      r_op_q;
    logic            r_zero_q;
    logic            r_bus_err;
    logic [CW_W-1:0] w_cw;
    logic [2:0]      w_op_eff;
    logic            w_zero_eff;
    logic            w_wait_state;
    logic            w_state_chg;
    logic            w_expired;

    // -------------------------------------------------------------------------
    // Memory wait timer
    // -------------------------------------------------------------------------
    assign w_wait_state = is_wait_state(r_state);
    assign w_state_chg  = (w_state_next != r_state);

    risc_wait_timer #(
        .WAIT_MAX (WAIT_MAX),
        .TO_W     (TO_W)
    ) u_wait_timer (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .i_count   (w_wait_state),
        .i_clear   (w_state_chg),
        .i_ready   (MEM_READY),
        .o_expired (w_expired)
    );

    // -------------------------------------------------------------------------
    // State and captured instruction context
    // -------------------------------------------------------------------------
    // NOTE: every clocked register uses non-blocking assignment. All flops
    // then sample pre-edge values, regardless of the order the blocks run in.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= FETCH_ADDR;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: op_q and zero_q are reset even though DECODE always writes them
    // before they are read. The OP_ADDR decode and the debug view then never
    // see X after reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_op_q   <= OP_HALT;
            r_zero_q <= 1'b0;
        end else if (r_state == DECODE) begin
            r_op_q   <= OPCODE;
            r_zero_q <= ALU_ZERO_FLAG;
        end
    end

    // BUS_ERR is set on a wait timeout and stays set until a restart from HALTED.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_bus_err <= 1'b0;
        end else if (w_expired) begin
            r_bus_err <= 1'b1;
        end else if ((r_state == HALTED) && RUN) begin
            r_bus_err <= 1'b0;
        end
    end

    // DECODE must act on the IR contents in the same cycle they are captured.
    // In that state the live inputs bypass the captured copies. Every later
    // state uses the captured copies.
    assign w_op_eff   = (r_state == DECODE) ? OPCODE        : r_op_q;
    assign w_zero_eff = (r_state == DECODE) ? ALU_ZERO_FLAG : r_zero_q;

    // -------------------------------------------------------------------------
    // Next-state and control-word decode
    // -------------------------------------------------------------------------
    // NOTE: both outputs get a default before the case statement. Any path
    // that does not assign them then falls back to "hold state, no strobes"
    // and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_cw         = '0;

        case (r_state)
            FETCH_ADDR: begin
                w_cw[CW_SEL] = 1'b1;
                w_cw[CW_RD]  = 1'b1;
                w_state_next = FETCH_WAIT;
            end

            FETCH_WAIT: begin
                w_cw[CW_SEL] = 1'b1;
                w_cw[CW_RD]  = 1'b1;
                if (MEM_READY) begin
                    w_cw[CW_LD_IR]  = 1'b1;
                    w_cw[CW_INC_PC] = 1'b1;
                    w_state_next    = DECODE;
                end else if (w_expired) begin
                    w_state_next = HALTED;
                end
            end

            DECODE: begin
                case (w_op_eff)
                    OP_HALT: w_state_next = HALTED;
                    OP_JUMP: begin
                        w_cw[CW_LD_PC] = 1'b1;
                        w_state_next   = FETCH_ADDR;
                    end
                    OP_JRZ: begin
                        // Taken branch skips the next word in memory.
                        w_cw[CW_INC_PC] = w_zero_eff;
                        w_state_next    = FETCH_ADDR;
                    end
                    default: w_state_next = OP_ADDR;
                endcase
            end

            OP_ADDR: begin
                if (is_read_op(w_op_eff)) begin
                    w_cw[CW_RD]  = 1'b1;
                    w_state_next = OP_WAIT;
                end else begin
                    // STORE: move ACC through the ALU so ALU_OUT holds the
                    // data to write.
                    w_cw[CW_ALU_EN] = 1'b1;
                    w_state_next    = WRITEBACK;
                end
            end

            OP_WAIT: begin
                w_cw[CW_RD] = 1'b1;
                if (MEM_READY) begin
                    w_cw[CW_ALU_EN] = 1'b1;
                    w_state_next    = EXECUTE;
                end else if (w_expired) begin
                    w_state_next = HALTED;
                end
            end

            EXECUTE: begin
                w_cw[CW_LD_AC] = 1'b1;
                w_state_next   = FETCH_ADDR;
            end

            WRITEBACK: begin
                w_cw[CW_DATA_E] = 1'b1;
                w_cw[CW_WR]     = 1'b1;
                if (MEM_READY) begin
                    w_state_next = FETCH_ADDR;
                end else if (w_expired) begin
                    w_state_next = HALTED;
                end
            end

            HALTED: begin
                w_cw[CW_HALT] = 1'b1;
                if (RUN) begin
                    w_state_next = FETCH_ADDR;
                end
            end

            default: w_state_next = FETCH_ADDR;
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign SEL     = w_cw[CW_SEL];
    assign RD      = w_cw[CW_RD];
    assign WR      = w_cw[CW_WR];
    assign LD_IR   = w_cw[CW_LD_IR];
    assign INC_PC  = w_cw[CW_INC_PC];
    assign LD_PC   = w_cw[CW_LD_PC];
    assign LD_AC   = w_cw[CW_LD_AC];
    assign DATA_E  = w_cw[CW_DATA_E];
    assign ALU_EN  = w_cw[CW_ALU_EN];
    assign HALT    = w_cw[CW_HALT];
    assign BUS_ERR = r_bus_err;
    assign STATE   = r_state;

endmodule : risc_ctrl_sequencer

// File: tb/tb_risc_ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// tb_risc_ctrl_sequencer
// Directed test of the instruction sequencer. Each step drives the inputs for
// one cycle and compares STATE and the packed strobe vector against
// hand-computed values. It then advances one clock.
// -----------------------------------------------------------------------------
module tb_risc_ctrl_sequencer;

    // Packed output order: {SEL,RD,WR,LD_IR,INC_PC,LD_PC,LD_AC,DATA_E,ALU_EN,HALT,BUS_ERR}
    localparam logic [10:0] M_SEL  = 11'h400;
    localparam logic [10:0] M_RD   = 11'h200;
    localparam logic [10:0] M_WR   = 11'h100;
    localparam logic [10:0] M_LDIR = 11'h080;
    localparam logic [10:0] M_INC  = 11'h040;
    localparam logic [10:0] M_LDPC = 11'h020;
    localparam logic [10:0] M_LDAC = 11'h010;
    localparam logic [10:0] M_DE   = 11'h008;
    localparam logic [10:0] M_ALU  = 11'h004;
    localparam logic [10:0] M_HALT = 11'h002;
    localparam logic [10:0] M_BERR = 11'h001;

    localparam logic [2:0] C_HALT  = 3'b000;
    localparam logic [2:0] C_JRZ   = 3'b001;
    localparam logic [2:0] C_ADD   = 3'b010;
    localparam logic [2:0] C_LOAD  = 3'b101;
    localparam logic [2:0] C_STORE = 3'b110;
    localparam logic [2:0] C_JUMP  = 3'b111;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [2:0] OPCODE;
    logic       ALU_ZERO_FLAG;
    logic       MEM_READY;
    logic       RUN;
    logic       SEL, RD, WR, LD_IR, INC_PC, LD_PC, LD_AC, DATA_E, ALU_EN, HALT, BUS_ERR;
    logic [2:0] STATE;
    logic [10:0] w_outs;

    int n_checks = 0;
    int n_errors = 0;

    risc_ctrl_sequencer #(
        .WAIT_MAX (15),
        .TO_W     (4)
    ) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .OPCODE        (OPCODE),
        .ALU_ZERO_FLAG (ALU_ZERO_FLAG),
        .MEM_READY     (MEM_READY),
        .RUN           (RUN),
        .SEL           (SEL),
        .RD            (RD),
        .WR            (WR),
        .LD_IR         (LD_IR),
        .INC_PC        (INC_PC),
        .LD_PC         (LD_PC),
        .LD_AC         (LD_AC),
        .DATA_E        (DATA_E),
        .ALU_EN        (ALU_EN),
        .HALT          (HALT),
        .BUS_ERR       (BUS_ERR),
        .STATE         (STATE)
    );

    always #5 CLK = ~CLK;

    assign w_outs = {SEL, RD, WR, LD_IR, INC_PC, LD_PC, LD_AC, DATA_E, ALU_EN, HALT, BUS_ERR};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, check mid-cycle, then move to just after the next edge.
    task automatic step(input string tag, input logic [2:0] op, input logic z,
                        input logic rdy, input logic run,
                        input logic [2:0] exp_st, input logic [10:0] exp_o);
        OPCODE        = op;
        ALU_ZERO_FLAG = z;
        MEM_READY     = rdy;
        RUN           = run;
        #1;
        check({tag, " state"}, 32'(STATE), 32'(exp_st));
        check({tag, " outs"}, 32'(w_outs), 32'(exp_o));
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST_N         = 1'b0;
        OPCODE        = C_HALT;
        ALU_ZERO_FLAG = 1'b0;
        MEM_READY     = 1'b0;
        RUN           = 1'b0;
        #3;
        check("reset state", 32'(STATE), 32'd0);
        check("reset outs", 32'(w_outs), 32'(M_SEL | M_RD));
        @(posedge CLK);
        #1;
        RST_N = 1'b1;

        // ADD with memory always ready: six cycles.
        // RUN held high to show it is ignored outside HALTED.
        step("add c0", C_ADD, 0, 1, 1, 3'd0, M_SEL | M_RD);
        step("add c1", C_ADD, 0, 1, 1, 3'd1, M_SEL | M_RD | M_LDIR | M_INC);
        step("add c2", C_ADD, 0, 1, 1, 3'd2, 11'h000);
        step("add c3", C_ADD, 0, 1, 1, 3'd3, M_RD);
        step("add c4", C_ADD, 0, 1, 1, 3'd4, M_RD | M_ALU);
        step("add c5", C_ADD, 0, 1, 0, 3'd5, M_LDAC);

        // STORE with memory held off for three WRITEBACK cycles.
        // MEM_READY is low in FETCH_ADDR, where it is ignored.
        step("st c0", C_STORE, 0, 0, 0, 3'd0, M_SEL | M_RD);
        step("st c1", C_STORE, 0, 1, 0, 3'd1, M_SEL | M_RD | M_LDIR | M_INC);
        step("st c2", C_STORE, 0, 1, 0, 3'd2, 11'h000);
        step("st c3", C_STORE, 0, 1, 0, 3'd3, M_ALU);
        for (int i = 0; i < 3; i++)
            step($sformatf("st wb%0d", i), C_STORE, 0, 0, 0, 3'd6, M_WR | M_DE);
        step("st wb3", C_STORE, 0, 1, 0, 3'd6, M_WR | M_DE);

        // JRZ taken, then JRZ not taken.
        step("jrz1 c0", C_JRZ, 1, 1, 0, 3'd0, M_SEL | M_RD);
        step("jrz1 c1", C_JRZ, 1, 1, 0, 3'd1, M_SEL | M_RD | M_LDIR | M_INC);
        step("jrz1 c2", C_JRZ, 1, 1, 0, 3'd2, M_INC);
        step("jrz0 c0", C_JRZ, 0, 1, 0, 3'd0, M_SEL | M_RD);
        step("jrz0 c1", C_JRZ, 0, 1, 0, 3'd1, M_SEL | M_RD | M_LDIR | M_INC);
        step("jrz0 c2", C_JRZ, 0, 1, 0, 3'd2, 11'h000);

        // JUMP: a single LD_PC cycle in DECODE.
        step("jmp c0", C_JUMP, 0, 1, 0, 3'd0, M_SEL | M_RD);
        step("jmp c1", C_JUMP, 0, 1, 0, 3'd1, M_SEL | M_RD | M_LDIR | M_INC);
        step("jmp c2", C_JUMP, 0, 1, 1, 3'd2, M_LDPC);

        // Fetch timeout: sixteen wait cycles, then HALTED with BUS_ERR set.
        step("to c0", C_JUMP, 0, 1, 0, 3'd0, M_SEL | M_RD);
        for (int k = 0; k < 16; k++)
            step($sformatf("to fw%0d", k), C_JUMP, 0, 0, 0, 3'd1, M_SEL | M_RD);
        step("to halt0", C_JUMP, 0, 0, 0, 3'd7, M_HALT | M_BERR);
        step("to halt1", C_JUMP, 0, 1, 1, 3'd7, M_HALT | M_BERR);

        // Ready arrives in the cycle the timer would expire: normal completion.
        step("edge c0", C_JUMP, 0, 1, 0, 3'd0, M_SEL | M_RD);
        for (int k = 0; k < 15; k++)
            step($sformatf("edge fw%0d", k), C_JUMP, 0, 0, 0, 3'd1, M_SEL | M_RD);
        step("edge fw15", C_JUMP, 0, 1, 0, 3'd1, M_SEL | M_RD | M_LDIR | M_INC);
        step("edge dec", C_JUMP, 0, 1, 0, 3'd2, M_LDPC);

        // HALT opcode, which persists until RUN.
        step("hlt c0", C_HALT, 0, 1, 0, 3'd0, M_SEL | M_RD);
        step("hlt c1", C_HALT, 0, 1, 0, 3'd1, M_SEL | M_RD | M_LDIR | M_INC);
        step("hlt c2", C_HALT, 0, 1, 0, 3'd2, 11'h000);
        step("hlt h0", C_HALT, 0, 1, 0, 3'd7, M_HALT);
        step("hlt h1", C_HALT, 0, 1, 0, 3'd7, M_HALT);
        step("hlt h2", C_HALT, 0, 1, 1, 3'd7, M_HALT);

        // LOAD, then asynchronous reset in the middle of OP_WAIT.
        step("ld c0", C_LOAD, 0, 1, 0, 3'd0, M_SEL | M_RD);
        step("ld c1", C_LOAD, 0, 1, 0, 3'd1, M_SEL | M_RD | M_LDIR | M_INC);
        step("ld c2", C_LOAD, 0, 1, 0, 3'd2, 11'h000);
        step("ld c3", C_LOAD, 0, 0, 0, 3'd3, M_RD);
        MEM_READY = 1'b0;
        #1;
        check("ld opwait state", 32'(STATE), 32'd4);
        check("ld opwait outs", 32'(w_outs), 32'(M_RD));
        #2;
        RST_N = 1'b0;
        #1;
        check("arst state", 32'(STATE), 32'd0);
        check("arst outs", 32'(w_outs), 32'(M_SEL | M_RD));
        @(posedge CLK);
        #1;
        check("arst hold state", 32'(STATE), 32'd0);
        RST_N = 1'b1;
        step("post c0", C_ADD, 0, 1, 0, 3'd0, M_SEL | M_RD);
        step("post c1", C_ADD, 0, 1, 0, 3'd1, M_SEL | M_RD | M_LDIR | M_INC);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_risc_ctrl_sequencer
